// File: rtl/pc_unit.sv
// Program-counter unit for the pipelined MIPS core: boot cycle, stall hold,
// prioritised redirects and capture of a redirect arriving during a stall.
// Optional misaligned-target trap is enabled with `define PC_ALIGN_CHECK_EN.
//
// state | meaning
// ------+------------------------------------------------------------
// BOOT  | first cycle after reset, pc = RESET_VEC not yet fetchable
// RUN   | normal fetch: sequential advance or live redirect
// PEND  | stalled with a captured redirect target waiting in pend_tgt
module pc_unit #(
  parameter int              WORD      = 32,
  parameter logic [WORD-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [WORD-1:0] EXC_VEC   = 32'h8000_0180,
  parameter int              INC       = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [WORD-1:0] br_target,
  input  logic            jmp_taken,
  input  logic [WORD-1:0] jmp_target,
  input  logic            exc_req,
  output logic [WORD-1:0] pc,
  output logic [WORD-1:0] pc_plus,
  output logic            pc_valid,
  output logic            redirect,
  output logic            pending,
  output logic            misalign
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [WORD-1:0] pend_tgt, pend_tgt_nxt;
  logic [WORD-1:0] pc_nxt;
  logic            pc_valid_nxt, redirect_nxt, misalign_nxt;
  logic            exc_load, tgt_load;
  logic [WORD-1:0] load_addr;

  assign pc_plus = pc + WORD'(INC);
  assign pending = (state == PEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_VEC;
      pc_valid <= 1'b0;
      redirect <= 1'b0;
      misalign <= 1'b0;
      pend_tgt <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      pc_valid <= pc_valid_nxt;
      redirect <= redirect_nxt;
      misalign <= misalign_nxt;
      pend_tgt <= pend_tgt_nxt;
    end
  end

  // Select what happens this edge; the actual pc load is resolved below.
  always_comb begin
    state_nxt    = state;
    pend_tgt_nxt = pend_tgt;
    pc_valid_nxt = pc_valid;
    exc_load     = 1'b0;
    tgt_load     = 1'b0;
    load_addr    = '0;
    unique case (state)
      BOOT: begin
        pc_valid_nxt = 1'b1;
        state_nxt    = RUN;
        exc_load     = exc_req;
      end
      RUN: begin
        if (exc_req) begin
          exc_load = 1'b1;
        end else if (stall) begin
          if (br_taken) begin
            pend_tgt_nxt = br_target;
            state_nxt    = PEND;
          end else if (jmp_taken) begin
            pend_tgt_nxt = jmp_target;
            state_nxt    = PEND;
          end
        end else if (br_taken) begin
          tgt_load  = 1'b1;
          load_addr = br_target;
        end else if (jmp_taken) begin
          tgt_load  = 1'b1;
          load_addr = jmp_target;
        end
      end
      PEND: begin
        if (exc_req) begin
          exc_load     = 1'b1;
          pend_tgt_nxt = '0;
          state_nxt    = RUN;
        end else if (stall) begin
          // A younger jump is squashed by the pending redirect; a newer branch wins.
          if (br_taken) pend_tgt_nxt = br_target;
        end else begin
          tgt_load     = 1'b1;
          load_addr    = br_taken ? br_target : pend_tgt;
          pend_tgt_nxt = '0;
          state_nxt    = RUN;
        end
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  always_comb begin
    redirect_nxt = 1'b0;
    misalign_nxt = 1'b0;
    pc_nxt       = pc;
    if (exc_load) begin
      pc_nxt       = EXC_VEC;
      redirect_nxt = 1'b1;
    end else if (tgt_load) begin
      redirect_nxt = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
      if (load_addr[1:0] != 2'b00) begin
        pc_nxt       = EXC_VEC;
        misalign_nxt = 1'b1;
      end else begin
        pc_nxt = load_addr;
      end
`else
      pc_nxt = load_addr & ~WORD'(3);
`endif
    end else if (state == RUN && !stall) begin
      pc_nxt = pc_plus;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit: boot, sequential, redirects,
// stall capture, exceptions, async reset, wrap-around and target alignment.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, br_taken, jmp_taken, exc_req;
  logic [31:0] br_target, jmp_target;
  logic [31:0] pc, pc_plus;
  logic        pc_valid, redirect, pending, misalign;

  int vectors = 0;
  int fails   = 0;

  localparam logic [31:0] EXC = 32'h8000_0180;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp_taken  (jmp_taken),
    .jmp_target (jmp_target),
    .exc_req    (exc_req),
    .pc         (pc),
    .pc_plus    (pc_plus),
    .pc_valid   (pc_valid),
    .redirect   (redirect),
    .pending    (pending),
    .misalign   (misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [31:0] epc, input logic ev,
                        input logic ered, input logic epend);
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".valid"}, {31'd0, pc_valid}, {31'd0, ev});
    chk({tag, ".redirect"}, {31'd0, redirect}, {31'd0, ered});
    chk({tag, ".pending"}, {31'd0, pending}, {31'd0, epend});
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; jmp_taken = 1'b0; exc_req = 1'b0;
    br_target = '0; jmp_target = '0;
    #1;
    chk_st("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    chk("reset.misalign", {31'd0, misalign}, 32'd0);
    #12 rst_n = 1'b1;
    #1 chk_st("released", 32'h0, 1'b0, 1'b0, 1'b0);
    step(); chk_st("boot", 32'h0, 1'b1, 1'b0, 1'b0);
    step(); chk_st("seq1", 32'h4, 1'b1, 1'b0, 1'b0);
    chk("seq1.pc_plus", pc_plus, 32'h8);
    step(); chk_st("seq2", 32'h8, 1'b1, 1'b0, 1'b0);

    br_taken = 1'b1; br_target = 32'h100;
    step(); chk_st("branch", 32'h100, 1'b1, 1'b1, 1'b0);
    br_taken = 1'b0;
    step(); chk_st("after_branch", 32'h104, 1'b1, 1'b0, 1'b0);

    // jump captured during a 3-cycle stall
    stall = 1'b1; jmp_taken = 1'b1; jmp_target = 32'h200;
    step(); chk_st("stall_jmp1", 32'h104, 1'b1, 1'b0, 1'b1);
    jmp_taken = 1'b0;
    step(); chk_st("stall_jmp2", 32'h104, 1'b1, 1'b0, 1'b1);
    step(); chk_st("stall_jmp3", 32'h104, 1'b1, 1'b0, 1'b1);
    stall = 1'b0;
    step(); chk_st("jmp_release", 32'h200, 1'b1, 1'b1, 1'b0);

    // newer branch overwrites captured jump
    stall = 1'b1; jmp_taken = 1'b1; jmp_target = 32'h200;
    step(); chk_st("pend_a", 32'h200, 1'b1, 1'b0, 1'b1);
    jmp_taken = 1'b0; br_taken = 1'b1; br_target = 32'h300;
    step(); chk_st("pend_br_over", 32'h200, 1'b1, 1'b0, 1'b1);
    br_taken = 1'b0; stall = 1'b0;
    step(); chk_st("pend_rel_300", 32'h300, 1'b1, 1'b1, 1'b0);

    // live branch on release beats the captured target
    stall = 1'b1; jmp_taken = 1'b1; jmp_target = 32'h200;
    step(); chk_st("pend_b", 32'h300, 1'b1, 1'b0, 1'b1);
    jmp_taken = 1'b0; stall = 1'b0; br_taken = 1'b1; br_target = 32'h400;
    step(); chk_st("live_br_400", 32'h400, 1'b1, 1'b1, 1'b0);
    br_taken = 1'b0;

    // jump while already pending is ignored
    stall = 1'b1; jmp_taken = 1'b1; jmp_target = 32'h200;
    step(); chk_st("pend_c", 32'h400, 1'b1, 1'b0, 1'b1);
    jmp_target = 32'h500;
    step(); chk_st("pend_jmp_ign", 32'h400, 1'b1, 1'b0, 1'b1);
    jmp_taken = 1'b0; stall = 1'b0;
    step(); chk_st("pend_rel_200", 32'h200, 1'b1, 1'b1, 1'b0);

    // branch and jump together: branch wins
    br_taken = 1'b1; br_target = 32'h700; jmp_taken = 1'b1; jmp_target = 32'h800;
    step(); chk_st("br_beats_jmp", 32'h700, 1'b1, 1'b1, 1'b0);
    br_taken = 1'b0; jmp_taken = 1'b0;

    // exception overrides stall and pending
    stall = 1'b1; jmp_taken = 1'b1; jmp_target = 32'h600;
    step(); chk_st("pend_d", 32'h700, 1'b1, 1'b0, 1'b1);
    jmp_taken = 1'b0; exc_req = 1'b1;
    step(); chk_st("exc_pend", EXC, 1'b1, 1'b1, 1'b0);
    exc_req = 1'b0; stall = 1'b0;
    step(); chk_st("after_exc", EXC + 32'h4, 1'b1, 1'b0, 1'b0);

    // asynchronous reset mid-cycle, with a capture in flight
    stall = 1'b1; jmp_taken = 1'b1; jmp_target = 32'h900;
    step(); chk_st("pend_e", EXC + 32'h4, 1'b1, 1'b0, 1'b1);
    #3 rst_n = 1'b0;
    #1 chk_st("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);
    stall = 1'b0; jmp_taken = 1'b0;
    #2 rst_n = 1'b1;
    // exception during boot
    exc_req = 1'b1;
    step(); chk_st("boot_exc", EXC, 1'b1, 1'b1, 1'b0);
    exc_req = 1'b0;
    step(); chk_st("boot_exc_seq", EXC + 32'h4, 1'b1, 1'b0, 1'b0);

    // wrap-around
    br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
    step(); chk_st("to_top", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
    chk("top.pc_plus", pc_plus, 32'h0);
    br_taken = 1'b0;
    step(); chk_st("wrap", 32'h0, 1'b1, 1'b0, 1'b0);

    // misaligned target
    br_taken = 1'b1; br_target = 32'h102;
    step();
`ifdef PC_ALIGN_CHECK_EN
    chk_st("misal", EXC, 1'b1, 1'b1, 1'b0);
    chk("misal.flag", {31'd0, misalign}, 32'd1);
`else
    chk_st("misal", 32'h100, 1'b1, 1'b1, 1'b0);
    chk("misal.flag", {31'd0, misalign}, 32'd0);
`endif
    br_taken = 1'b0;
    step();
    chk("misal.pulse_end", {31'd0, misalign}, 32'd0);
    chk("misal.redir_end", {31'd0, redirect}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
